// File: rtl/data_ram.sv
// ---------------------------------------------------------------------------
// data_ram
//   Word-organised data memory serving pipeline loads and stores. Loads return
//   the full aligned 32-bit word one cycle after the request. Stores arrive
//   already lane-merged. After reset an optional clear sequencer zeroes every
//   word before any request is accepted. A load and a store to the same word
//   in the same cycle is write-first. Requests outside the window
//   [ADDR_BASE, ADDR_BASE + DEPTH*4) are flagged on addr_err_o.
//
// Ports
//   clk           in   1   system clock, rising edge
//   arst_n        in   1   asynchronous reset, active low
//   mem_r_ena_i   in   1   load request this cycle
//   mem_r_addr_i  in   32  load byte address, bits [1:0] ignored
//   mem_r_data_o  out  32  load word, registered
//   mem_r_valid_o out  1   one-cycle pulse per accepted load
//   mem_w_ena_i   in   1   store request this cycle
//   mem_w_addr_i  in   32  store byte address, bits [1:0] ignored
//   mem_w_data_i  in   32  store word, already lane-merged
//   busy_o        out  1   clear in progress, requests ignored
//   addr_err_o    out  1   pulse: a request last cycle was out of range
//
// Request semantics: there is no ready signal. In RUN every request whose
// enable is high is taken in that cycle (one load plus one store per cycle).
// While busy_o is high, requests are dropped with no side effect at all.
// ---------------------------------------------------------------------------
module data_ram #(
    parameter int          DEPTH      = 4096,
    parameter logic [31:0] ADDR_BASE  = 32'h0000_0000,
    parameter bit          INIT_CLEAR = 1'b1
) (
    input  logic        clk,
    input  logic        arst_n,
    input  logic        mem_r_ena_i,
    input  logic [31:0] mem_r_addr_i,
    output logic [31:0] mem_r_data_o,
    output logic        mem_r_valid_o,
    input  logic        mem_w_ena_i,
    input  logic [31:0] mem_w_addr_i,
    input  logic [31:0] mem_w_data_i,
    output logic        busy_o,
    output logic        addr_err_o
);

    localparam int          AW    = $clog2(DEPTH);
    // Window size computed in 33 bits so a 4 GiB window cannot wrap to zero.
    localparam logic [32:0] LIMIT = 33'(DEPTH) * 33'd4;

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;
    localparam logic [0:0] ST_RESET = (INIT_CLEAR != 1'b0) ? ST_CLEAR : ST_RUN;

    logic [31:0]   r_mem [DEPTH];
    logic [0:0]    r_state;
    logic [AW-1:0] r_clr_idx;
    logic [31:0]   r_rdata;
    logic          r_rvalid;
    logic          r_err;

    logic [31:0]   w_r_off;
    logic [31:0]   w_w_off;
    logic          w_r_in;
    logic          w_w_in;
    logic [AW-1:0] w_r_idx;
    logic [AW-1:0] w_w_idx;
    logic          w_run;
    logic          w_same;
    logic          w_we;
    logic [AW-1:0] w_waddr;
    logic [31:0]   w_wdata;

    // Address decode: offset from base, range test, word index.
    assign w_r_off = mem_r_addr_i - ADDR_BASE;
    assign w_w_off = mem_w_addr_i - ADDR_BASE;
    assign w_r_in  = ({1'b0, w_r_off} < LIMIT);
    assign w_w_in  = ({1'b0, w_w_off} < LIMIT);
    assign w_r_idx = w_r_off[AW+1:2];
    assign w_w_idx = w_w_off[AW+1:2];

    assign w_run   = (r_state == ST_RUN);
    // Write-first forwarding when both ports hit the same in-range word.
    assign w_same  = mem_w_ena_i && w_w_in && (w_w_idx == w_r_idx);

    // Single RAM write port shared between the clear sequencer and stores.
    always_comb begin
        w_we    = 1'b0;
        w_waddr = '0;
        w_wdata = '0;
        if (r_state == ST_CLEAR) begin
            w_we    = 1'b1;
            w_waddr = r_clr_idx;
            w_wdata = '0;
        end else if (mem_w_ena_i && w_w_in) begin
            w_we    = 1'b1;
            w_waddr = w_w_idx;
            w_wdata = mem_w_data_i;
        end
    end

    // RAM array: deliberately not reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

    // Clear sequencer. The last index written moves the FSM to RUN, so busy_o
    // is high for exactly DEPTH cycles after reset release.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state   <= ST_RESET;
            r_clr_idx <= '0;
        end else if (r_state == ST_CLEAR) begin
            r_clr_idx <= r_clr_idx + 1'b1;
            if (r_clr_idx == AW'(DEPTH - 1)) begin
                r_state <= ST_RUN;
            end
        end
    end

    // Load response and error pulse.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
            r_err    <= 1'b0;
        end else if (w_run) begin
            r_rvalid <= mem_r_ena_i;
            r_err    <= (mem_r_ena_i && !w_r_in) || (mem_w_ena_i && !w_w_in);
            if (mem_r_ena_i) begin
                if (!w_r_in) begin
                    r_rdata <= '0;
                end else if (w_same) begin
                    r_rdata <= mem_w_data_i;
                end else begin
                    r_rdata <= r_mem[w_r_idx];
                end
            end
        end else begin
            r_rvalid <= 1'b0;
            r_err    <= 1'b0;
        end
    end

    assign mem_r_data_o  = r_rdata;
    assign mem_r_valid_o = r_rvalid;
    assign addr_err_o    = r_err;
    assign busy_o        = (r_state == ST_CLEAR);

endmodule

// File: tb/tb_data_ram.sv
// ---------------------------------------------------------------------------
// tb_data_ram
//   Directed bench for data_ram with DEPTH=16, ADDR_BASE=0, INIT_CLEAR=1.
//   A vector table drives one request cycle per row and checks the registered
//   outputs after that edge; hand-written sequences cover the clear timing,
//   drops during clear and reset in the middle of the clear.
// ---------------------------------------------------------------------------
module tb_data_ram;

    localparam int DEPTH = 16;

    logic        clk;
    logic        arst_n;
    logic        mem_r_ena_i;
    logic [31:0] mem_r_addr_i;
    logic [31:0] mem_r_data_o;
    logic        mem_r_valid_o;
    logic        mem_w_ena_i;
    logic [31:0] mem_w_addr_i;
    logic [31:0] mem_w_data_i;
    logic        busy_o;
    logic        addr_err_o;

    int total;
    int bad;

    data_ram #(
        .DEPTH      (DEPTH),
        .ADDR_BASE  (32'h0000_0000),
        .INIT_CLEAR (1'b1)
    ) dut (
        .clk           (clk),
        .arst_n        (arst_n),
        .mem_r_ena_i   (mem_r_ena_i),
        .mem_r_addr_i  (mem_r_addr_i),
        .mem_r_data_o  (mem_r_data_o),
        .mem_r_valid_o (mem_r_valid_o),
        .mem_w_ena_i   (mem_w_ena_i),
        .mem_w_addr_i  (mem_w_addr_i),
        .mem_w_data_i  (mem_w_data_i),
        .busy_o        (busy_o),
        .addr_err_o    (addr_err_o)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- vector table ----------------
    typedef struct {
        logic        r_ena;
        logic [31:0] r_addr;
        logic        w_ena;
        logic [31:0] w_addr;
        logic [31:0] w_data;
        logic        exp_valid;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    localparam int NVEC = 19;
    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic r_ena, input logic [31:0] r_addr,
                                input logic w_ena, input logic [31:0] w_addr,
                                input logic [31:0] w_data, input logic exp_valid,
                                input logic [31:0] exp_data, input logic exp_err);
        vec_t v;
        v.r_ena     = r_ena;
        v.r_addr    = r_addr;
        v.w_ena     = w_ena;
        v.w_addr    = w_addr;
        v.w_data    = w_data;
        v.exp_valid = exp_valid;
        v.exp_data  = exp_data;
        v.exp_err   = exp_err;
        return v;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r_ena, input logic [31:0] r_addr,
                         input logic w_ena, input logic [31:0] w_addr,
                         input logic [31:0] w_data);
        mem_r_ena_i  = r_ena;
        mem_r_addr_i = r_addr;
        mem_w_ena_i  = w_ena;
        mem_w_addr_i = w_addr;
        mem_w_data_i = w_data;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    endtask

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " data"},  mem_r_data_o,         32'h0);
        chk({tag, " valid"}, {31'h0, mem_r_valid_o}, 32'h0);
        chk({tag, " err"},   {31'h0, addr_err_o},    32'h0);
        chk({tag, " busy"},  {31'h0, busy_o},        32'h1);
    endtask

    // Counts cycles with busy_o high from now on, bounded. With poke set, a
    // store to 0x0 and an out-of-range load are driven on one mid-clear cycle
    // and must be silently dropped.
    task automatic count_busy(input bit poke, output int n);
        n = 0;
        while (busy_o && n < 100) begin
            if (poke && n == 4) drive(1'b1, 32'h40, 1'b1, 32'h0, 32'hFFFF_FFFF);
            else                idle();
            step();
            n++;
            if (poke && n == 5) begin
                chk("clear drop valid", {31'h0, mem_r_valid_o}, 32'h0);
                chk("clear drop err",   {31'h0, addr_err_o},    32'h0);
            end
        end
        idle();
    endtask

    // ---------------- test ----------------
    initial begin
        int n;
        total = 0;
        bad   = 0;
        arst_n = 1'b0;
        idle();

        //               r_ena r_addr        w_ena w_addr        w_data         v     data           err
        vecs[0]  = mk(1'b0, 32'h0,        1'b1, 32'h8,        32'hDEAD_BEEF, 1'b0, 32'h0,         1'b0);
        vecs[1]  = mk(1'b1, 32'hA,        1'b0, 32'h0,        32'h0,         1'b1, 32'hDEAD_BEEF, 1'b0);
        vecs[2]  = mk(1'b1, 32'h4,        1'b1, 32'h4,        32'h1234_5678, 1'b1, 32'h1234_5678, 1'b0);
        vecs[3]  = mk(1'b1, 32'h4,        1'b0, 32'h0,        32'h0,         1'b1, 32'h1234_5678, 1'b0);
        vecs[4]  = mk(1'b1, 32'h40,       1'b0, 32'h0,        32'h0,         1'b1, 32'h0,         1'b1);
        vecs[5]  = mk(1'b0, 32'h0,        1'b1, 32'h40,       32'hCAFE_F00D, 1'b0, 32'h0,         1'b1);
        vecs[6]  = mk(1'b1, 32'h0,        1'b0, 32'h0,        32'h0,         1'b1, 32'h0,         1'b0);
        vecs[7]  = mk(1'b0, 32'h0,        1'b1, 32'h0,        32'h1,         1'b0, 32'h0,         1'b0);
        vecs[8]  = mk(1'b1, 32'h8,        1'b1, 32'h4,        32'h2,         1'b1, 32'hDEAD_BEEF, 1'b0);
        vecs[9]  = mk(1'b0, 32'h0,        1'b1, 32'h8,        32'h3,         1'b0, 32'hDEAD_BEEF, 1'b0);
        vecs[10] = mk(1'b1, 32'h0,        1'b0, 32'h0,        32'h0,         1'b1, 32'h1,         1'b0);
        vecs[11] = mk(1'b1, 32'h4,        1'b0, 32'h0,        32'h0,         1'b1, 32'h2,         1'b0);
        vecs[12] = mk(1'b1, 32'h8,        1'b0, 32'h0,        32'h0,         1'b1, 32'h3,         1'b0);
        vecs[13] = mk(1'b0, 32'h0,        1'b0, 32'h0,        32'h0,         1'b0, 32'h3,         1'b0);
        vecs[14] = mk(1'b1, 32'h3C,       1'b1, 32'h3C,       32'hA5A5_A5A5, 1'b1, 32'hA5A5_A5A5, 1'b0);
        vecs[15] = mk(1'b1, 32'h3F,       1'b0, 32'h0,        32'h0,         1'b1, 32'hA5A5_A5A5, 1'b0);
        vecs[16] = mk(1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0,       32'h0,         1'b1, 32'h0,         1'b1);
        vecs[17] = mk(1'b1, 32'h0,        1'b1, 32'h44,       32'h77,        1'b1, 32'h1,         1'b1);
        vecs[18] = mk(1'b1, 32'h4,        1'b0, 32'h0,        32'h0,         1'b1, 32'h2,         1'b0);

        // Reset state, before any clock edge matters.
        #12;
        chk_reset_outputs("reset");

        // Release away from the edge and time the clear.
        step();
        arst_n = 1'b1;
        count_busy(1'b1, n);
        chk("clear cycles", 32'(n), 32'd16);

        // Vector table: one request cycle per row.
        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].r_ena, vecs[i].r_addr, vecs[i].w_ena, vecs[i].w_addr, vecs[i].w_data);
            step();
            chk($sformatf("vec%0d valid", i), {31'h0, mem_r_valid_o}, {31'h0, vecs[i].exp_valid});
            chk($sformatf("vec%0d data", i),  mem_r_data_o,          vecs[i].exp_data);
            chk($sformatf("vec%0d err", i),   {31'h0, addr_err_o},    {31'h0, vecs[i].exp_err});
        end
        idle();

        // Reset asserted mid-RUN: outputs drop immediately, without an edge.
        arst_n = 1'b0;
        #1;
        chk_reset_outputs("run reset");
        step();
        step();
        arst_n = 1'b1;

        // Let the clear reach index 7, then reset again.
        for (int i = 0; i < 7; i++) step();
        chk("mid clear busy", {31'h0, busy_o}, 32'h1);
        arst_n = 1'b0;
        #1;
        chk_reset_outputs("clear reset");
        step();
        arst_n = 1'b1;
        count_busy(1'b0, n);
        chk("restart clear cycles", 32'(n), 32'd16);

        // Clear overwrote earlier contents, including the top word.
        drive(1'b1, 32'h3C, 1'b0, 32'h0, 32'h0);
        step();
        chk("post clear 0x3C valid", {31'h0, mem_r_valid_o}, 32'h1);
        chk("post clear 0x3C data",  mem_r_data_o,          32'h0);
        drive(1'b1, 32'h4, 1'b0, 32'h0, 32'h0);
        step();
        chk("post clear 0x4 data", mem_r_data_o, 32'h0);
        idle();
        step();
        chk("idle valid", {31'h0, mem_r_valid_o}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
